// File: rtl/nde_seq_ctrl.sv
// rtl/nde_seq_ctrl.sv - NDe record sequencer: header count parse, countdown, registered payload output
//
// Purpose: accepts {payload, count} beats, takes the record length from the
// first (header) beat, forwards every payload through a one-stage registered
// valid/ready output, flags the final beat with out_last and pulses rw once
// the final beat has left. Zero-length headers are dropped with err_zero_len.
//
// Optional feature macro: NDE_SEQ_STATS_EN adds rec_count / stall_count.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_data/in_valid/in_ready  input beat {payload[DATA_W-1:0], count[CNT_W-1:0]}
//   out_data/out_valid/out_ready/out_last  registered payload stream
//   rw                         one-cycle end-of-record strobe (DONE state)
//   busy                       high whenever the sequencer is not IDLE
//   err_zero_len               one-cycle pulse after a count-0 header
//   rec_count, stall_count     statistics (NDE_SEQ_STATS_EN only)
module nde_seq_ctrl #(
  parameter int CNT_W  = 32,
  parameter int DATA_W = 128
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CNT_W+DATA_W-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    rw,
  output logic                    busy,
  output logic                    err_zero_len
`ifdef NDE_SEQ_STATS_EN
  ,
  output logic [31:0]             rec_count,
  output logic [31:0]             stall_count
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, TAIL, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic                rw_q, rw_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                in_fire, out_fire;
  logic [CNT_W-1:0]    hdr_cnt;
  logic [DATA_W-1:0]   payload;

  assign hdr_cnt = in_data[CNT_W-1:0];
  assign payload = in_data[CNT_W +: DATA_W];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    rw_d        = 1'b0;
    err_d       = 1'b0;

    // The output register may be refilled in the same cycle it drains,
    // which gives full throughput inside a record.
    in_ready = ((state_q == IDLE) || (state_q == RUN)) && (!out_valid_q || out_ready);
    in_fire  = in_valid && in_ready;
    out_fire = out_valid_q && out_ready;

    if (out_fire) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (in_fire) begin
          if (hdr_cnt == '0) begin
            err_d = 1'b1;
          end else begin
            out_valid_d = 1'b1;
            out_data_d  = payload;
            if (hdr_cnt == CNT_ONE) begin
              out_last_d = 1'b1;
              state_d    = TAIL;
            end else begin
              out_last_d = 1'b0;
              cnt_d      = hdr_cnt - CNT_ONE;
              state_d    = RUN;
            end
          end
        end
      end
      RUN: begin
        // Count field of non-header beats is ignored; cnt holds beats still owed.
        if (in_fire) begin
          out_valid_d = 1'b1;
          out_data_d  = payload;
          if (cnt_q == CNT_ONE) begin
            out_last_d = 1'b1;
            state_d    = TAIL;
          end else begin
            out_last_d = 1'b0;
            cnt_d      = cnt_q - CNT_ONE;
          end
        end
      end
      TAIL: begin
        if (out_fire) begin
          rw_d    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      rw_q        <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      rw_q        <= rw_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;
  assign rw           = rw_q;
  assign busy         = busy_q;
  assign err_zero_len = err_q;

`ifdef NDE_SEQ_STATS_EN
  logic [31:0] rec_count_q, rec_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    rec_count_d   = rec_count_q + 32'(state_q == DONE);
    stall_count_d = stall_count_q + 32'(out_valid_q && !out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_count_q   <= '0;
      stall_count_q <= '0;
    end else begin
      rec_count_q   <= rec_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign rec_count   = rec_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_nde_seq_ctrl.sv
// tb/tb_nde_seq_ctrl.sv - scoreboard bench for nde_seq_ctrl
`timescale 1ns/1ps
module tb_nde_seq_ctrl;
  localparam int CNT_W  = 32;
  localparam int DATA_W = 128;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic [CNT_W+DATA_W-1:0] in_data = '0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [DATA_W-1:0]       out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;
  logic                    rw;
  logic                    busy;
  logic                    err_zero_len;
`ifdef NDE_SEQ_STATS_EN
  logic [31:0]             rec_count;
  logic [31:0]             stall_count;
`endif

  logic rdy_mode  = 1'b0;
  logic rdy_fixed = 1'b1;
  logic rdy_rand  = 1'b1;
  assign out_ready = rdy_mode ? rdy_rand : rdy_fixed;

  nde_seq_ctrl #(.CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .rw           (rw),
    .busy         (busy),
    .err_zero_len (err_zero_len)
`ifdef NDE_SEQ_STATS_EN
    ,
    .rec_count    (rec_count),
    .stall_count  (stall_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    rdy_rand = ($urandom_range(0, 3) != 0);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a record is just "beats still owed"; every accepted
  // payload becomes one expected output, flagged last when it closes the record.
  typedef struct packed {
    logic [127:0] data;
    logic         last;
  } exp_t;

  exp_t   q[$];
  longint rem       = 0;
  int     cyc       = 0;
  int     last_xfer = -100;
  int     zero_acc  = -100;
  int     hdr_gap   = -1;
`ifdef NDE_SEQ_STATS_EN
  logic [31:0] exp_rec   = '0;
  logic [31:0] exp_stall = '0;
`endif

  always @(negedge clk) begin
    bit rw_exp, busy_exp, rdy_exp;
    logic [31:0]  n;
    logic [127:0] p;
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_rw", rw, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err_zero_len, 0);
`ifdef NDE_SEQ_STATS_EN
      chk("rst_rec_count", rec_count, 0);
      chk("rst_stall_count", stall_count, 0);
      exp_rec   = '0;
      exp_stall = '0;
`endif
      q.delete();
      rem       = 0;
      last_xfer = -100;
      zero_acc  = -100;
    end else begin
      rw_exp   = (cyc == last_xfer + 1);
      busy_exp = (rem != 0) || (q.size() != 0) || rw_exp;
      rdy_exp  = !(rem == 0 && (q.size() != 0 || rw_exp)) && (q.size() == 0 || out_ready);
      chk("rw", rw, rw_exp);
      chk("err_zero_len", err_zero_len, (cyc == zero_acc + 1));
      chk("busy", busy, busy_exp);
      chk("out_valid", out_valid, (q.size() != 0));
      chk("in_ready", in_ready, rdy_exp);
`ifdef NDE_SEQ_STATS_EN
      chk("rec_count", rec_count, exp_rec);
      chk("stall_count", stall_count, exp_stall);
      if (rw_exp) exp_rec = exp_rec + 1;
      if (q.size() != 0 && !out_ready) exp_stall = exp_stall + 1;
`endif
      if (q.size() != 0) begin
        chk("out_data", out_data, q[0].data);
        chk("out_last", out_last, q[0].last);
        if (out_ready) begin
          if (q[0].last) last_xfer = cyc;
          void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        n = in_data[31:0];
        p = in_data[159:32];
        if (rem == 0) begin
          if (last_xfer >= 0) begin
            hdr_gap = cyc - last_xfer;
            chk("hdr_gap_min", (hdr_gap >= 2), 1);
          end
          if (n == 0) begin
            zero_acc = cyc;
          end else begin
            q.push_back({p, (n == 32'd1)});
            rem = longint'(n) - 1;
          end
        end else begin
          q.push_back({p, (rem == 1)});
          rem = rem - 1;
        end
      end
    end
    cyc++;
  end

  task automatic idle(input int k);
    in_valid = 1'b0;
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] n, input logic [127:0] p);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = {p, n};
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready never rose, required within 200 cycles");
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    idle(2);
    rst_n    = 1'b1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nb;
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // N=3 record, out_ready high
    send(32'd3, 128'hA);
    send(32'hDEAD, 128'hB);
    send(32'h7, 128'hC);
    idle(6);

    // Zero-length header then a single-beat record
    send(32'd0, 128'h5A5A);
    send(32'd1, 128'hD);
    idle(6);

    // N=4 with a 5-cycle output stall on beat 2
    do_reset();
    send(32'd4, 128'h40);
    send(32'd0, 128'h41);
    in_valid  = 1'b0;
    rdy_fixed = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rdy_fixed = 1'b1;
    send(32'd9, 128'h42);
    send(32'd9, 128'h43);
    idle(6);
`ifdef NDE_SEQ_STATS_EN
    chk("stall_count_total", stall_count, 5);
    chk("rec_count_total", rec_count, 1);
`endif

    // Back-to-back N=2 then N=1 with in_valid held high
    send(32'd2, 128'h20);
    send(32'd0, 128'h21);
    send(32'd1, 128'h30);
    idle(6);
    chk("b2b_hdr_gap", hdr_gap, 2);

    // Reset during beat 2 of an N=5 record
    send(32'd5, 128'h50);
    send(32'd0, 128'h51);
    do_reset();
    send(32'd1, 128'hE);
    idle(6);

    // Maximum count: 1000 beats, no out_last may appear, then reset
    send(32'hFFFF_FFFF, rnd128());
    for (int i = 0; i < 999; i++) send($urandom, rnd128());
    do_reset();
    idle(2);

    // Randomized records with random gaps and backpressure
    rdy_mode = 1'b1;
    for (int r = 0; r < 30; r++) begin
      n  = $urandom_range(0, 6);
      nb = (n == 0) ? 1 : n;
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        send((b == 0) ? 32'(n) : $urandom, rnd128());
      end
    end
    in_valid = 1'b0;
    rdy_mode = 1'b0;
    idle(10);
    chk("drain_queue_empty", q.size(), 0);
    chk("drain_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
